// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: 3-5 cycles per instruction plus one per mem_ready=0 cycle, which stalls in place.
// Optional JR support in EXEC_R is compiled in with MC_CTRL_JR_EN.
module mc_main_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic [5:0]       funct_o,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             iord,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  WB_R   = 4'd3,
        ADDR   = 4'd4,  MEM_RD = 4'd5,  WB_MEM = 4'd6,  MEM_WR = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  EXEC_I = 4'd10, WB_I   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = EXEC_R;
                    OP_LW, OP_SW:  state_d = ADDR;
                    OP_BEQ:        state_d = BRANCH;
                    OP_J:          state_d = JUMP;
                    OP_ADDI:       state_d = EXEC_I;
                    default:       state_d = FETCH;
                endcase
            end
`ifdef MC_CTRL_JR_EN
            EXEC_R: state_d = (funct == FN_JR) ? FETCH : WB_R;
`else
            EXEC_R: state_d = WB_R;
`endif
            ADDR:   state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: if (mem_ready) state_d = WB_MEM;
            MEM_WR: if (mem_ready) state_d = FETCH;
            EXEC_I: state_d = WB_I;
            default: state_d = FETCH;
        endcase
    end

    // Reset masks every control output so an abandoned instruction cannot write anything.
    always_comb begin
        ALUOp      = 2'b11;
        funct_o    = 6'h00;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        illegal    = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_re    = 1'b1;
                    alu_src_b = 2'b01;
                    ALUOp     = 2'b00;
                    funct_o   = FN_ADD;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    ALUOp     = 2'b00;
                    funct_o   = FN_ADD;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    ALUOp     = 2'b00;
                    funct_o   = funct;
`ifdef MC_CTRL_JR_EN
                    if (funct == FN_JR) begin
                        ALUOp   = 2'b11;
                        funct_o = 6'h00;
                        pc_we   = 1'b1;
                        pc_src  = 2'b11;
                        retire  = 1'b1;
                    end
`endif
                end
                WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                    retire  = 1'b1;
                end
                ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = 2'b00;
                    funct_o   = FN_ADD;
                end
                MEM_RD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                end
                WB_MEM: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                MEM_WR: begin
                    mem_we = 1'b1;
                    iord   = 1'b1;
                    retire = mem_ready;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    ALUOp     = 2'b00;
                    funct_o   = FN_SUB;
                    pc_src    = 2'b01;
                    pc_we     = zero;
                    retire    = 1'b1;
                end
                JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                    retire = 1'b1;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = 2'b00;
                    funct_o   = FN_ADD;
                end
                WB_I: begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_cnt = rst ? '0 : cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed scenarios plus randomized instruction streams against an effect-level model.
module tb_mc_main_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] opcode, funct;
    logic zero, mem_ready;
    logic [1:0] ALUOp, pc_src, alu_src_b;
    logic [5:0] funct_o;
    logic pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg, alu_src_a, illegal, retire;
    logic [CW-1:0] instr_cnt;
    logic [3:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [63:0] trace;

    // instruction classes used by the model
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_ADDI = 5, C_ILL = 6, C_JR = 7;

`ifdef MC_CTRL_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    mc_main_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .funct_o(funct_o), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord),
        .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .illegal(illegal), .retire(retire),
        .instr_cnt(instr_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Run one instruction open-loop: the model knows its length and where memory waits fall.
    task automatic run_instr(input int cls, input int fw, input int mw_in, input logic z,
                             input logic [5:0] fn, input string tag);
        logic [5:0] op;
        int base, len, mw, ncyc;
        int n_ir, n_pc, n_reg, n_we, n_we_rdy, n_re, n_ill, n_ret, n_waitwr;
        int ir_at;
        bit ret_last, has_mem, is_jr_taken;
        logic [1:0] last_src, exp_src, exp_aluop;
        logic [5:0] exp_fn, dec_fn, ex_fn;
        logic [1:0] ex_aluop;
        logic rd_dst, rd_m2r;
        int exp_pc, exp_reg, exp_ret, exp_re;
        case (cls)
            C_R, C_JR: op = 6'h00;
            C_LW:      op = 6'h23;
            C_SW:      op = 6'h2B;
            C_BEQ:     op = 6'h04;
            C_J:       op = 6'h02;
            C_ADDI:    op = 6'h08;
            default:   op = 6'h3F;
        endcase
        if (cls == C_ILL) begin
            do op = 6'($urandom_range(0, 63));
            while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
        end
        has_mem = (cls == C_LW || cls == C_SW);
        is_jr_taken = (cls == C_JR) && JR_EN;
        mw = has_mem ? mw_in : 0;
        case (cls)
            C_BEQ, C_J: base = 3;
            C_LW:       base = 5;
            C_ILL:      base = 2;
            C_JR:       base = JR_EN ? 3 : 4;
            default:    base = 4;
        endcase
        len = base + fw + mw;
        n_ir = 0; n_pc = 0; n_reg = 0; n_we = 0; n_we_rdy = 0; n_re = 0; n_ill = 0; n_ret = 0; n_waitwr = 0;
        ir_at = -1; ret_last = 0; last_src = 2'bxx; trace = '0;
        dec_fn = 'x; ex_fn = 'x; ex_aluop = 'x; rd_dst = 'x; rd_m2r = 'x;
        for (int c = 0; c < len; c++) begin
            opcode = op; funct = fn; zero = z;
            mem_ready = !((c < fw) || (has_mem && c >= fw + 3 && c < fw + 3 + mw));
            @(negedge clk);
            trace = {trace[59:0], state_o};
            if (ir_we) begin n_ir++; ir_at = c; end
            if (pc_we) begin n_pc++; last_src = pc_src; end
            if (reg_we) begin n_reg++; rd_dst = reg_dst; rd_m2r = mem_to_reg; end
            if (mem_we) n_we++;
            if (mem_we && mem_ready) n_we_rdy++;
            if (mem_re) n_re++;
            if (illegal) n_ill++;
            if (retire) begin n_ret++; ret_last = (c == len - 1); end
            if (!mem_ready && (ir_we || pc_we || reg_we)) n_waitwr++;
            if (c == fw + 1) dec_fn = funct_o;
            if (c == fw + 2) begin ex_fn = funct_o; ex_aluop = ALUOp; end
            @(posedge clk); #1;
        end
        exp_ret = (cls == C_ILL) ? 0 : 1;
        exp_cnt = (exp_cnt + exp_ret) % (1 << CW);
        exp_pc  = 1 + ((cls == C_BEQ && z) ? 1 : 0) + (cls == C_J ? 1 : 0) + (is_jr_taken ? 1 : 0);
        exp_src = (cls == C_J) ? 2'b10 : (cls == C_BEQ && z) ? 2'b01 : is_jr_taken ? 2'b11 : 2'b00;
        exp_reg = (cls == C_R || cls == C_LW || cls == C_ADDI || (cls == C_JR && !JR_EN)) ? 1 : 0;
        exp_re  = fw + 1 + ((cls == C_LW) ? mw + 1 : 0);

        n_cmp++; if (state_o !== 4'd0) begin n_bad++; $display("FAIL %s end_state: got %0d want 0", tag, state_o); end
        n_cmp++; if (instr_cnt !== CW'(exp_cnt)) begin n_bad++; $display("FAIL %s instr_cnt: got %0d want %0d", tag, instr_cnt, exp_cnt); end
        n_cmp++; if (n_ret !== exp_ret || (exp_ret == 1 && !ret_last)) begin n_bad++; $display("FAIL %s retire: got %0d pulses last=%0d want %0d at last cycle", tag, n_ret, ret_last, exp_ret); end
        n_cmp++; if (n_ir !== 1 || ir_at !== fw) begin n_bad++; $display("FAIL %s ir_we: got %0d at cycle %0d want 1 at %0d", tag, n_ir, ir_at, fw); end
        n_cmp++; if (n_pc !== exp_pc || last_src !== exp_src) begin n_bad++; $display("FAIL %s pc_we: got %0d src %b want %0d src %b", tag, n_pc, last_src, exp_pc, exp_src); end
        n_cmp++; if (n_reg !== exp_reg) begin n_bad++; $display("FAIL %s reg_we: got %0d want %0d", tag, n_reg, exp_reg); end
        if (exp_reg == 1) begin
            n_cmp++;
            if (rd_dst !== (cls == C_R || cls == C_JR) || rd_m2r !== (cls == C_LW)) begin
                n_bad++; $display("FAIL %s reg_dst/mem_to_reg: got %b/%b want %b/%b", tag, rd_dst, rd_m2r, (cls == C_R || cls == C_JR), (cls == C_LW));
            end
        end
        n_cmp++; if (n_we !== (cls == C_SW ? mw + 1 : 0) || n_we_rdy !== (cls == C_SW ? 1 : 0)) begin n_bad++; $display("FAIL %s mem_we: got %0d (%0d ready) want %0d", tag, n_we, n_we_rdy, cls == C_SW ? mw + 1 : 0); end
        n_cmp++; if (n_re !== exp_re) begin n_bad++; $display("FAIL %s mem_re: got %0d want %0d", tag, n_re, exp_re); end
        n_cmp++; if (n_waitwr !== 0) begin n_bad++; $display("FAIL %s wait_writes: got %0d want 0", tag, n_waitwr); end
        n_cmp++; if (n_ill !== (cls == C_ILL ? 1 : 0)) begin n_bad++; $display("FAIL %s illegal: got %0d want %0d", tag, n_ill, cls == C_ILL ? 1 : 0); end
        n_cmp++; if (dec_fn !== 6'h20) begin n_bad++; $display("FAIL %s decode_funct: got %h want 20", tag, dec_fn); end
        if (cls != C_ILL && !is_jr_taken) begin
            exp_fn = (cls == C_R || cls == C_JR) ? fn : (cls == C_BEQ) ? 6'h22 : (cls == C_J) ? 6'h00 : 6'h20;
            exp_aluop = (cls == C_J) ? 2'b11 : 2'b00;
            n_cmp++;
            if (ex_fn !== exp_fn || ex_aluop !== exp_aluop) begin
                n_bad++; $display("FAIL %s exec_alu: got funct %h aluop %b want %h %b", tag, ex_fn, ex_aluop, exp_fn, exp_aluop);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 6'h23; funct = 6'h20; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if (ALUOp !== 2'b11 || state_o !== 4'd0 ||
                {funct_o, pc_we, pc_src, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, illegal, retire, instr_cnt} !== '0) begin
                n_bad++; $display("FAIL reset_outputs: got aluop %b state %0d mem_re %b ir_we %b cnt %0d want 11/0/0/0/0",
                                  ALUOp, state_o, mem_re, ir_we, instr_cnt);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state_o !== 4'd0 || instr_cnt !== '0 || mem_re !== 1'b1 || ir_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: got state %0d cnt %0d mem_re %b ir_we %b want 0 0 1 0", state_o, instr_cnt, mem_re, ir_we);
        end
        @(posedge clk); #1;
        exp_cnt = 0;
    endtask

    task automatic test_rtype();
        run_instr(C_R, 0, 0, 1'b0, 6'h20, "add");
        n_cmp++;
        if (trace[15:0] !== 16'h0123) begin n_bad++; $display("FAIL add_trace: got %h want 0123", trace[15:0]); end
    endtask

    task automatic test_lw();
        run_instr(C_LW, 0, 2, 1'b0, 6'h00, "lw_wait2");
        n_cmp++;
        if (trace[27:0] !== 28'h0145556) begin n_bad++; $display("FAIL lw_trace: got %h want 0145556", trace[27:0]); end
    endtask

    task automatic test_beq();
        run_instr(C_BEQ, 0, 0, 1'b1, 6'h00, "beq_taken");
        run_instr(C_BEQ, 1, 0, 1'b0, 6'h00, "beq_not_taken");
    endtask

    task automatic test_illegal();
        opcode = 6'h3F;
        run_instr(C_ILL, 0, 0, 1'b0, 6'h00, "illegal");
    endtask

    task automatic test_jr();
        run_instr(C_JR, 0, 0, 1'b0, 6'h08, "jr");
    endtask

    task automatic test_mid_reset();
        logic [5:0] ops [4] = '{6'h2B, 6'h2B, 6'h2B, 6'h2B};
        logic       rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            opcode = ops[c]; funct = 6'h00; zero = 1'b0; mem_ready = rdy[c];
            if (c < 3) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        n_cmp++;
        if (state_o !== 4'd7 || mem_we !== 1'b1 || retire !== 1'b0) begin
            n_bad++; $display("FAIL memwr_wait: got state %0d mem_we %b retire %b want 7 1 0", state_o, mem_we, retire);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if (mem_we !== 1'b0 || retire !== 1'b0) begin n_bad++; $display("FAIL rst_mask: got mem_we %b retire %b want 0 0", mem_we, retire); end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state_o !== 4'd0 || mem_we !== 1'b0 || instr_cnt !== '0) begin
            n_bad++; $display("FAIL rst_abandon: got state %0d mem_we %b cnt %0d want 0 0 0", state_o, mem_we, instr_cnt);
        end
        @(posedge clk); #1;
        exp_cnt = 0;
    endtask

    task automatic test_random();
        logic [5:0] rfn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
        for (int i = 0; i < 40; i++) begin
            int cls;
            cls = $urandom_range(0, 7);
            run_instr(cls, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      (cls == C_JR) ? 6'h08 : rfn[$urandom_range(0, 5)], $sformatf("rand%0d_cls%0d", i, cls));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_illegal();
        test_jr();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle main control FSM for the MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives all datapath enables.
- Sits directly upstream of the ALU control unit: it supplies that unit's 2-bit ALUOp and 6-bit funct inputs.
- Also owns the memory-stall handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- opcode, input, 6, instr[31:26] from the IR.
- funct, input, 6, instr[5:0] from the IR.
- zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory access completes this cycle.
- ALUOp, output, 2, to ALU control; 2'b00 = decode funct, 2'b11 = idle (ALU control yields NOP).
- funct_o, output, 6, funct presented to ALU control.
- pc_we, output, 1, PC write.
- pc_src, output, 2, 00 ALU result, 01 ALUOut register, 10 jump target, 11 rs value.
- ir_we, output, 1, IR write.
- iord, output, 1, 0 = PC address, 1 = ALUOut address.
- mem_re, output, 1, memory read request.
- mem_we, output, 1, memory write request.
- reg_we, output, 1, register file write.
- reg_dst, output, 1, 0 = rt, 1 = rd.
- mem_to_reg, output, 1, 0 = ALUOut, 1 = MDR.
- alu_src_a, output, 1, 0 = PC, 1 = rs.
- alu_src_b, output, 2, 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- illegal, output, 1, one-cycle pulse on an unsupported opcode.
- retire, output, 1, one-cycle pulse when an instruction completes.
- instr_cnt, output, CNT_W, retired-instruction count.
- state_o, output, 4, current state (debug).

Behaviour:
- State encoding (4-bit): FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, ADDR=4, MEM_RD=5, WB_MEM=6, MEM_WR=7, BRANCH=8, JUMP=9, EXEC_I=10, WB_I=11.
- Output timing: outputs are a combinational decode of state, mem_ready and zero. Any output not listed for a state is 0, except ALUOp=2'b11 and funct_o=6'h00.
- Reset:
  - rst high at a clock edge: state<=FETCH, instr_cnt<=0.
  - While rst is high, every output is forced to 0, except ALUOp=2'b11 and state_o, which shows the registered state.
  - rst asserted mid-instruction abandons that instruction. No retire pulse and no further writes.
- FETCH:
  - Drives mem_re=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00, funct_o=6'h20 (ADD).
  - ir_we=pc_we=mem_ready, pc_src=00.
  - Holds while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, ALUOp=00, funct_o=6'h20 (branch target into ALUOut).
  - Next state by opcode: 000000 to EXEC_R; 100011 or 101011 to ADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to EXEC_I.
  - Any other opcode: illegal=1 this cycle, go to FETCH, no retire.
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUOp=00, funct_o=funct; go to WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0, retire; go to FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, ALUOp=00, funct_o=6'h20. Go to MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD: mem_re=1, iord=1. Holds until mem_ready=1, then goes to WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1, retire; go to FETCH.
- MEM_WR: mem_we=1, iord=1. Holds until mem_ready=1, then retires in the same cycle and goes to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, ALUOp=00, funct_o=6'h22 (SUB), pc_src=01.
  - pc_we=zero; retire; go to FETCH.
- JUMP: pc_we=1, pc_src=10, retire; go to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, ALUOp=00, funct_o=6'h20; go to WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0, retire; go to FETCH.
- Latency with zero wait states: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5 cycles. Each mem_ready=0 cycle adds one.
- Write enables are never asserted during a wait cycle: mem_we and mem_re remain high but ir_we, pc_we and reg_we are low.
- instr_cnt increments by 1 on every retire and wraps from all-ones to 0.
- ir_we and pc_we in FETCH are both asserted only in the mem_ready cycle.

Optional Feature:
- Macro: MC_CTRL_JR_EN.
- Defined: in EXEC_R with funct=6'h08 (JR), drive pc_we=1, pc_src=11, ALUOp=11, retire, go to FETCH. No WB_R, no reg_we.
- Undefined: JR is treated as an ordinary R-type. funct_o=6'h08 is forwarded, WB_R follows, reg_we is asserted to rd.

Test Plan:
- Reset held 2 cycles, then R-type add (opcode 0, funct 6'h20), mem_ready=1 -> states 0,1,2,3,0; funct_o=6'h20 in EXEC_R; reg_we=1 and reg_dst=1 in WB_R; instr_cnt=1.
- lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; reg_we only in WB_MEM; mem_to_reg=1; no ir_we/pc_we during waits.
- beq with zero=1, then again with zero=0 -> pc_we=1 with pc_src=01 once; pc_we=0 the second time; funct_o=6'h22; instr_cnt +2.
- opcode 6'h3F -> illegal pulse in DECODE; return to FETCH; instr_cnt unchanged; no writes.
- rst asserted in MEM_WR while mem_ready=0 -> next cycle state FETCH, mem_we=0, instr_cnt=0.
- JR (funct 6'h08) -> with MC_CTRL_JR_EN: pc_src=11, pc_we=1, reg_we never asserted. Without the macro: WB_R with reg_we=1.
